spiflash_line_cache: RTL and testbench
======================================

Name: spiflash_line_cache

Overview:
Direct-mapped, read-only line cache between the CPU instruction/data Wishbone bus and the SPI flash XIP wrapper.
- Hits: returns flash words with one-cycle latency.
- Misses: fills a whole line through the wrapper's Wishbone read port, one word per master transaction.
- Flush input: driven by firmware after flash config or erase/program, so no stale data is served.

Parameters:
LINES, 8, number of cache lines; power of 2, >=2
WORDS, 4, 32-bit words per line; power of 2, >=2
ADDR_BITS, 24, flash byte-address width passed downstream

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  asynchronous active-low reset
s_adr_i  in  32  CPU byte address; bits [1:0] ignored; bits above ADDR_BITS ignored
s_cyc_i  in  1  CPU bus cycle
s_stb_i  in  1  CPU strobe
s_dat_o  out  32  read data
s_ack_o  out  1  single-cycle acknowledge
m_adr_o  out  32  address to flash wrapper; bits [31:ADDR_BITS] and [1:0] always 0
m_cyc_o  out  1  master cycle
m_stb_o  out  1  master strobe; equal to m_cyc_o
m_dat_i  in  32  flash word
m_ack_i  in  1  flash acknowledge
flush_i  in  1  pulse; invalidates all lines

Behaviour:
- Reset: wb_clk_i single clock domain; async active-low reset.
  - Outputs while reset is held: s_ack_o=0, s_dat_o=0, m_cyc_o=m_stb_o=0, m_adr_o=0.
  - All valid bits cleared, state IDLE, counters 0.
  - Reset mid-fill aborts immediately; the partial line stays invalid.
- Address split (word address a=s_adr_i[ADDR_BITS-1:2]):
  - offset = low log2(WORDS) bits of a.
  - index = next log2(LINES) bits.
  - tag = remaining upper bits.
- Storage: data array LINES*WORDS x 32; tag and valid per line; registers or inferred RAM with a combinational read.
- State machine: IDLE, ACK, FILL.
- IDLE:
  - Moves only when s_cyc_i & s_stb_i, s_ack_o=0, and no flush this cycle.
  - Hit (valid[index] and tag match): register the word into s_dat_o and go to ACK.
  - Miss: latch index/tag, set fill counter to 0, go to FILL.
- ACK:
  - s_ack_o=1 for exactly one cycle, then IDLE.
  - s_ack_o is never asserted on two consecutive cycles, so a held strobe is re-looked-up cleanly.
- FILL:
  - m_cyc_o=m_stb_o=1.
  - m_adr_o = {tag,index,counter,2'b00}; first word is offset 0, then counter+1.
  - Strobe is held steady until m_ack_i, as required downstream.
  - On m_ack_i: write m_dat_i to data[index][counter]; if counter==WORDS-1, write tag, set valid, drop m_cyc_o the same edge, go IDLE.
  - Otherwise counter+1, and m_adr_o updates the next cycle with strobe still high.
  - Re-entry to IDLE re-looks up the still-pending request, which now hits.
  - Miss latency = WORDS master transactions + 2 cycles.
- CPU abandons a request (s_cyc_i dropped) during FILL: the fill runs to completion, no s_ack_o is generated, and the line becomes valid.
- flush_i:
  - Clears all valid bits on the next edge.
  - Asserted in IDLE with a request pending: flush wins; the lookup is deferred one cycle and then misses.
  - During FILL: sets flush_pending; the completing fill does not set valid and clears flush_pending. The pending request then refills.
  - During ACK: the ack completes with the already-registered data.
- Writes: s_we is not supported; the flash window is read-only.
- m_ack_i outside FILL is ignored.

Optional Feature:
Macro SPIFLASH_CACHE_STATS_EN.
- Defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0].
  - hit count increments on each IDLE hit decision; miss count increments on each IDLE miss decision. The post-fill re-lookup is not counted as a hit.
  - Both wrap modulo 2^32, reset to 0, and are cleared by flush_i.
- Not defined: ports and logic are absent; behaviour otherwise identical.

Test Plan:
- Cold read 0x00000104, flash model acks each strobe after 3 cycles, word = address:
  - Exactly 4 master reads at 0x100, 0x104, 0x108, 0x10C.
  - s_ack_o asserted with s_dat_o=0x00000104.
  - Miss counter=1.
- Then read 0x0000010C:
  - No master activity.
  - s_ack_o one cycle after the strobe with 0x0000010C.
  - Hit counter=1.
- Conflict (LINES=8, WORDS=4): read 0x000100 then 0x000180 (same index, different tag), then 0x000100 again → three separate 4-word fills.
- flush_i pulsed during the second word of a fill for 0x200:
  - The fill completes all 4 words with no premature ack.
  - The line is not marked valid; the request refills (8 master reads total), then acks 0x200.
- s_cyc_i dropped mid-fill at 0x300:
  - No s_ack_o.
  - A subsequent read of 0x304 hits with 0 master reads.
- wb_rst_n_i asserted during the third fill word:
  - All outputs 0 immediately.
  - After release, a read of the same address performs a full 4-word fill.

Source files
------------

// File: rtl/spiflash_line_cache.sv
// Direct-mapped read-only line cache in front of the SPI flash XIP wrapper.
// Hits acknowledge one cycle after the strobe; misses fill a whole line
// through the master port, one word per transaction, then re-look up.
// Optional build macro SPIFLASH_CACHE_STATS_EN adds hit/miss counters.
module spiflash_line_cache #(
  parameter int LINES     = 8,
  parameter int WORDS     = 4,
  parameter int ADDR_BITS = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] s_adr_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic [31:0] m_adr_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
`ifdef SPIFLASH_CACHE_STATS_EN
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o,
`endif
  input  logic        flush_i
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_BITS - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, ACK, FILL} state_t;

  // Address split of the incoming CPU request
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_adr;

  assign req_off    = s_adr_i[2 +: OFF_W];
  assign req_idx    = s_adr_i[2+OFF_W +: IDX_W];
  assign req_tag    = s_adr_i[2+OFF_W+IDX_W +: TAG_W];
  assign unused_adr = ^s_adr_i;

  // Storage: data words and tags need no reset, only valid bits do
  logic [31:0]      mem_q [0:LINES*WORDS-1];
  logic [TAG_W-1:0] tag_q [0:LINES-1];

  state_t           state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [TAG_W-1:0] ftag_q, ftag_d;
  logic [31:0]      dat_q, dat_d;
  logic             ack_q, ack_d;
  logic             cyc_q, cyc_d;
  logic             fpend_q, fpend_d;   // flush seen while a fill was in flight
  logic             refill_q, refill_d; // next lookup is the post-fill re-lookup
  logic             mem_we, tag_we, hit_inc, miss_inc;
  logic             hit;

  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Next-state and datapath decisions for the IDLE/ACK/FILL controller
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    fidx_d   = fidx_q;
    ftag_d   = ftag_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    cyc_d    = cyc_q;
    fpend_d  = fpend_q;
    refill_d = refill_q;
    mem_we   = 1'b0;
    tag_we   = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        refill_d = 1'b0;
        // A flush in the same cycle defers the lookup so it sees cleared valids
        if (s_cyc_i && s_stb_i && !ack_q && !flush_i) begin
          if (hit) begin
            dat_d   = mem_q[{req_idx, req_off}];
            ack_d   = 1'b1;
            state_d = ACK;
            hit_inc = !refill_q;
          end else begin
            fidx_d   = req_idx;
            ftag_d   = req_tag;
            cnt_d    = '0;
            cyc_d    = 1'b1;
            state_d  = FILL;
            miss_inc = 1'b1;
          end
        end
      end
      ACK: state_d = IDLE;
      FILL: begin
        if (flush_i) fpend_d = 1'b1;
        if (m_ack_i) begin
          mem_we = 1'b1;
          if (cnt_q == OFF_W'(WORDS-1)) begin
            tag_we = 1'b1;
            if (!(fpend_q || flush_i)) valid_d[fidx_q] = 1'b1;
            fpend_d  = 1'b0;
            cyc_d    = 1'b0;
            refill_d = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) valid_d = '0;
  end

  // Controller and registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      cnt_q    <= '0;
      fidx_q   <= '0;
      ftag_q   <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      cyc_q    <= 1'b0;
      fpend_q  <= 1'b0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      fidx_q   <= fidx_d;
      ftag_q   <= ftag_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      cyc_q    <= cyc_d;
      fpend_q  <= fpend_d;
      refill_q <= refill_d;
    end
  end

  // Line data and tag writes from the fill path
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem_q[{fidx_q, cnt_q}] <= m_dat_i;
    if (tag_we) tag_q[fidx_q] <= ftag_q;
  end

  logic [ADDR_BITS-1:0] fill_adr;
  assign fill_adr = {ftag_q, fidx_q, cnt_q, 2'b00};

  assign s_dat_o = dat_q;
  assign s_ack_o = ack_q;
  assign m_cyc_o = cyc_q;
  assign m_stb_o = cyc_q;
  assign m_adr_o = cyc_q ? 32'(fill_adr) : 32'h0;

`ifdef SPIFLASH_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Lookup statistics, cleared together with the valid bits
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, hit_inc};
    miss_cnt_d = miss_cnt_q + {31'b0, miss_inc};
    if (flush_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  // Counter registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_spiflash_line_cache.sv
// Bench for spiflash_line_cache: flash model acks 3 cycles after strobe with
// word = address; read data and master addresses checked through queues.
module tb_spiflash_line_cache;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_adr;
  logic        s_cyc, s_stb;
  logic [31:0] s_dat;
  logic        s_ack;
  logic [31:0] m_adr;
  logic        m_cyc, m_stb;
  logic [31:0] m_dat;
  logic        m_ack;
  logic        flush;
`ifdef SPIFLASH_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  spiflash_line_cache #(.LINES(8), .WORDS(4), .ADDR_BITS(24)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .s_adr_i(s_adr), .s_cyc_i(s_cyc), .s_stb_i(s_stb),
    .s_dat_o(s_dat), .s_ack_o(s_ack),
    .m_adr_o(m_adr), .m_cyc_o(m_cyc), .m_stb_o(m_stb),
    .m_dat_i(m_dat), .m_ack_i(m_ack),
`ifdef SPIFLASH_CACHE_STATS_EN
    .hit_count_o(hit_cnt), .miss_count_o(miss_cnt),
`endif
    .flush_i(flush)
  );

  int checks = 0;
  int failures = 0;
  int mreads = 0;
  int acks = 0;
  int mwait = 0;
  logic prev_ack = 1'b0;
  logic [31:0] exp_d[$];
  logic [31:0] exp_m[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  // Flash model and CPU-side monitor, both on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ack = 1'b0;
      mwait = 0;
      prev_ack = 1'b0;
    end else begin
      if (s_ack) begin
        acks++;
        chk("ack_back_to_back", {31'b0, prev_ack}, 32'h0);
        if (exp_d.size() == 0) chk("ack_unexpected", 32'h1, 32'h0);
        else chk("rdata", s_dat, exp_d.pop_front());
      end
      prev_ack = s_ack;
      if (m_ack) begin
        m_ack = 1'b0;
        mwait = 0;
      end else if (m_cyc) begin
        chk("stb_eq_cyc", {31'b0, m_stb}, 32'h1);
        mwait++;
        if (mwait == 3) begin
          m_ack = 1'b1;
          m_dat = m_adr;
          mreads++;
          if (exp_m.size() == 0) chk("m_unexpected", m_adr, 32'hFFFFFFFF);
          else chk("m_adr", m_adr, exp_m.pop_front());
        end
      end else begin
        mwait = 0;
      end
    end
  end

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_m.push_back(base + 32'(4 * i));
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] a, input logic [31:0] exp,
                          input int exp_mr, input int exp_lat);
    int start;
    int cyc;
    @(posedge clk); #1;
    start = mreads;
    cyc = 0;
    exp_d.push_back(exp);
    s_adr = a; s_cyc = 1'b1; s_stb = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!s_ack && cyc < 300);
    s_cyc = 1'b0; s_stb = 1'b0;
    chk({tag, "_acked"}, {31'b0, s_ack}, 32'h1);
    chk({tag, "_mreads"}, 32'(mreads - start), 32'(exp_mr));
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    if (!s_ack) exp_d.delete();
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_s_ack"}, {31'b0, s_ack}, 32'h0);
    chk({tag, "_s_dat"}, s_dat, 32'h0);
    chk({tag, "_m_cyc"}, {31'b0, m_cyc}, 32'h0);
    chk({tag, "_m_stb"}, {31'b0, m_stb}, 32'h0);
    chk({tag, "_m_adr"}, m_adr, 32'h0);
  endtask

  initial begin
    int start;
    int cyc;
    int acks0;
    logic flushed;
    rst_n = 1'b0; s_adr = '0; s_cyc = 1'b0; s_stb = 1'b0;
    m_dat = '0; m_ack = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Cold miss then hit in the same line
    push_line(32'h100);
    cpu_read("cold", 32'h104, 32'h104, 4, 0);
`ifdef SPIFLASH_CACHE_STATS_EN
    chk("miss_count", miss_cnt, 32'd1);
`endif
    cpu_read("hit", 32'h10C, 32'h10C, 0, 1);
`ifdef SPIFLASH_CACHE_STATS_EN
    chk("hit_count", hit_cnt, 32'd1);
`endif

    // Conflict: same index, different tags evict each other
    pulse_flush();
    push_line(32'h100);
    cpu_read("conf_a", 32'h100, 32'h100, 4, 0);
    push_line(32'h180);
    cpu_read("conf_b", 32'h180, 32'h180, 4, 0);
    push_line(32'h100);
    cpu_read("conf_a2", 32'h100, 32'h100, 4, 0);

    // Flush during the second fill word: line not kept, request refills
    push_line(32'h200);
    push_line(32'h200);
    @(posedge clk); #1;
    start = mreads; cyc = 0; flushed = 1'b0;
    exp_d.push_back(32'h200);
    s_adr = 32'h200; s_cyc = 1'b1; s_stb = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      flush = 1'b0;
      if (!flushed && mreads - start == 1) begin
        flush = 1'b1;
        flushed = 1'b1;
      end
    end while (!s_ack && cyc < 300);
    flush = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
    chk("flush_fill_acked", {31'b0, s_ack}, 32'h1);
    chk("flush_fill_mreads", 32'(mreads - start), 32'd8);

    // CPU abandons mid-fill: fill completes silently, line becomes valid
    push_line(32'h300);
    @(posedge clk); #1;
    start = mreads; cyc = 0; acks0 = acks;
    s_adr = 32'h300; s_cyc = 1'b1; s_stb = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (mreads - start < 2 && cyc < 300);
    s_cyc = 1'b0; s_stb = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (m_cyc && cyc < 300);
    repeat (3) @(posedge clk);
    #1;
    chk("abandon_no_ack", 32'(acks - acks0), 32'd0);
    chk("abandon_mreads", 32'(mreads - start), 32'd4);
    cpu_read("abandon_hit", 32'h304, 32'h304, 0, 1);

    // Reset during the third fill word
    exp_m.push_back(32'h400);
    exp_m.push_back(32'h404);
    @(posedge clk); #1;
    start = mreads; cyc = 0;
    s_adr = 32'h400; s_cyc = 1'b1; s_stb = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (mreads - start < 2 && cyc < 300);
    chk("pre_reset_mreads", 32'(mreads - start), 32'd2);
    rst_n = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
    #1 chk_idle_outputs("mid_fill_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_line(32'h400);
    cpu_read("post_reset", 32'h400, 32'h400, 4, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_m_drained", 32'(exp_m.size()), 32'd0);
    chk("exp_d_drained", 32'(exp_d.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
